// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Bundle of the write-back arbiter's bus signals: the ALU result
//               path, the long-op issue path, the long-result valid/ready
//               handshake, the registered regfile write controls, and the
//               scoreboard/status outputs.
//               slave  : the arbiter side (consumes requests, drives rf_*)
//               master : the requester side (drives requests, observes status)
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic           alu_we;
    logic [4:0]     alu_wn;
    logic [31:0]    alu_d;
    logic           iss_valid;
    logic [4:0]     iss_wn;
    logic           lng_valid;
    logic [4:0]     lng_wn;
    logic [31:0]    lng_d;
    logic           lng_ready;
    logic           rf_we;
    logic [4:0]     rf_wn;
    logic [31:0]    rf_d;
    logic [31:0]    pend;
    logic [AW:0]    occ;
    logic [1:0]     err;

    modport slave (
        input  alu_we, alu_wn, alu_d,
        input  iss_valid, iss_wn,
        input  lng_valid, lng_wn, lng_d,
        output lng_ready,
        output rf_we, rf_wn, rf_d,
        output pend, occ, err
    );

    modport master (
        output alu_we, alu_wn, alu_d,
        output iss_valid, iss_wn,
        output lng_valid, lng_wn, lng_d,
        input  lng_ready,
        input  rf_we, rf_wn, rf_d,
        input  pend, occ, err
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Write-back arbiter for the single regfile write port.
//               ALU results win unconditionally; long-latency results use a
//               valid/ready handshake and are queued in a DEPTH-entry FIFO
//               when they cannot be written at once. Keeps a per-register
//               pending scoreboard for issued long ops and sticky hazard
//               error flags. All outputs are registered.
// Ports       : clk    - clock, rising edge
//               clrn   - asynchronous active-low reset
//               bus    - rf_wb_arbiter_if.slave (ALU, issue, long-result
//                        handshake, rf_we/rf_wn/rf_d, pend, occ, err)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           clrn,
    rf_wb_arbiter_if.slave      bus
);
    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     c_FULL = (AW+1)'(DEPTH);

    // State
    logic [36:0]    mem_q [DEPTH];      // {wn, d}
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    occ_q, occ_d;
    logic           rf_we_q, rf_we_d;
    logic [4:0]     rf_wn_q, rf_wn_d;
    logic [31:0]    rf_d_q, rf_d_d;
    logic [31:0]    pend_q, pend_d;
    logic [1:0]     err_q, err_d;

    // Combinational
    logic           w_full, w_empty;
    logic           w_alu_v, w_lng_v;
    logic           w_pop, w_direct, w_push;
    logic [36:0]    w_head;
    logic           w_lclr;
    logic [4:0]     w_lclr_wn;
    logic           w_iss_v;

    always_comb begin
        w_full    = (occ_q == c_FULL);
        w_empty   = (occ_q == '0);
        w_alu_v   = bus.alu_we && (bus.alu_wn != 5'd0);
        // Accepted long result with a real destination; r0 results are
        // handshaken but otherwise dropped.
        w_lng_v   = bus.lng_valid && !w_full && (bus.lng_wn != 5'd0);
        w_pop     = !w_alu_v && !w_empty;
        w_direct  = !w_alu_v && w_empty && w_lng_v;
        w_push    = w_lng_v && !w_direct;
        w_head    = mem_q[rd_q];
        w_iss_v   = bus.iss_valid && (bus.iss_wn != 5'd0);

        rf_we_d   = 1'b0;
        rf_wn_d   = rf_wn_q;
        rf_d_d    = rf_d_q;
        w_lclr    = 1'b0;
        w_lclr_wn = 5'd0;

        if (w_alu_v) begin
            rf_we_d = 1'b1;
            rf_wn_d = bus.alu_wn;
            rf_d_d  = bus.alu_d;
        end else if (w_pop) begin
            rf_we_d   = 1'b1;
            rf_wn_d   = w_head[36:32];
            rf_d_d    = w_head[31:0];
            w_lclr    = 1'b1;
            w_lclr_wn = w_head[36:32];
        end else if (w_direct) begin
            rf_we_d   = 1'b1;
            rf_wn_d   = bus.lng_wn;
            rf_d_d    = bus.lng_d;
            w_lclr    = 1'b1;
            w_lclr_wn = bus.lng_wn;
        end

        // Clear first so that a same-cycle issue to the same register wins.
        pend_d = pend_q;
        if (w_lclr) begin
            pend_d[w_lclr_wn] = 1'b0;
        end
        if (w_iss_v) begin
            pend_d[bus.iss_wn] = 1'b1;
        end

        err_d = err_q;
        if (w_alu_v && pend_q[bus.alu_wn]) begin
            err_d[0] = 1'b1;
        end
        // Reissuing a register whose pending write retires this very cycle
        // is legal.
        if (w_iss_v && pend_q[bus.iss_wn] &&
            !(w_lclr && (w_lclr_wn == bus.iss_wn))) begin
            err_d[1] = 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO storage needs no reset: pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q] <= {bus.lng_wn, bus.lng_d};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            rf_we_q <= 1'b0;
            rf_wn_q <= 5'd0;
            rf_d_q  <= 32'd0;
            pend_q  <= 32'd0;
            err_q   <= 2'b00;
        end else begin
            if (w_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            occ_q   <= occ_d;
            rf_we_q <= rf_we_d;
            rf_wn_q <= rf_wn_d;
            rf_d_q  <= rf_d_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign bus.lng_ready = !w_full;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wn     = rf_wn_q;
    assign bus.rf_d      = rf_d_q;
    assign bus.pend      = pend_q;
    assign bus.occ       = occ_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Self-checking bench for rf_wb_arbiter: a table of single-cycle
//               vectors plus directed sequences for reset mid-stream, FIFO
//               fill/drain ordering and same-cycle pend clear/set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    localparam int DEPTH = 4;

    logic clk;
    logic clrn;
    int   checks;
    int   failures;

    rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH)) u_dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_we;
        logic [4:0]  alu_wn;
        logic [31:0] alu_d;
        logic        iss_v;
        logic [4:0]  iss_wn;
        logic        lng_v;
        logic [4:0]  lng_wn;
        logic [31:0] lng_d;
        logic        e_we;
        logic [4:0]  e_wn;
        logic [31:0] e_d;
        logic [31:0] e_pend;
        logic [2:0]  e_occ;
        logic [1:0]  e_err;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        input logic aw, input logic [4:0] awn, input logic [31:0] ad,
        input logic iv, input logic [4:0] iwn,
        input logic lv, input logic [4:0] lwn, input logic [31:0] ld,
        input logic ewe, input logic [4:0] ewn, input logic [31:0] ed,
        input logic [31:0] ep, input logic [2:0] eo, input logic [1:0] ee);
        vec_t v;
        v.alu_we = aw;  v.alu_wn = awn; v.alu_d = ad;
        v.iss_v  = iv;  v.iss_wn = iwn;
        v.lng_v  = lv;  v.lng_wn = lwn; v.lng_d = ld;
        v.e_we   = ewe; v.e_wn   = ewn; v.e_d   = ed;
        v.e_pend = ep;  v.e_occ  = eo;  v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic aw, input logic [4:0] awn, input logic [31:0] ad,
                         input logic iv, input logic [4:0] iwn,
                         input logic lv, input logic [4:0] lwn, input logic [31:0] ld);
        bus.alu_we = aw;  bus.alu_wn = awn; bus.alu_d = ad;
        bus.iss_valid = iv; bus.iss_wn = iwn;
        bus.lng_valid = lv; bus.lng_wn = lwn; bus.lng_d = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        tick();
    endtask

    // Expected per-cycle values for the FIFO fill/drain sequence
    int exp_rdy [14] = '{1,1,1,1,0,0,0,0,0,1,1,1,1,1};
    int exp_occ [14] = '{1,2,3,4,4,4,4,4,3,3,2,1,0,0};
    int exp_wn  [14] = '{1,1,1,1,1,1,1,1,8,9,10,11,12,12};
    int exp_we  [14] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0};

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        clrn = 1'b0;

        // Table: single-cycle behaviours starting from reset
        tbl[0]  = mk(0,0,0,           0,0, 0,0,0,            0,0,32'h0,        32'h0,   0,2'b00);
        tbl[1]  = mk(1,5,32'h1234,    0,0, 0,0,0,            1,5,32'h1234,     32'h0,   0,2'b00);
        tbl[2]  = mk(1,0,32'hFFFF,    0,0, 0,0,0,            0,5,32'h1234,     32'h0,   0,2'b00);
        tbl[3]  = mk(0,0,0,           1,7, 0,0,0,            0,5,32'h1234,     32'h80,  0,2'b00);
        tbl[4]  = mk(0,0,0,           0,0, 1,7,32'hDEADBEEF, 1,7,32'hDEADBEEF, 32'h0,   0,2'b00);
        tbl[5]  = mk(0,0,0,           0,0, 1,0,32'h5555,     0,7,32'hDEADBEEF, 32'h0,   0,2'b00);
        tbl[6]  = mk(0,0,0,           1,3, 0,0,0,            0,7,32'hDEADBEEF, 32'h8,   0,2'b00);
        tbl[7]  = mk(1,3,32'h33,      0,0, 0,0,0,            1,3,32'h33,       32'h8,   0,2'b01);
        tbl[8]  = mk(0,0,0,           0,0, 0,0,0,            0,3,32'h33,       32'h8,   0,2'b01);
        tbl[9]  = mk(0,0,0,           1,4, 0,0,0,            0,3,32'h33,       32'h18,  0,2'b01);
        tbl[10] = mk(0,0,0,           1,4, 0,0,0,            0,3,32'h33,       32'h18,  0,2'b11);
        tbl[11] = mk(0,0,0,           0,0, 1,3,32'h3,        1,3,32'h3,        32'h10,  0,2'b11);
        tbl[12] = mk(0,0,0,           1,4, 1,4,32'h4,        1,4,32'h4,        32'h10,  0,2'b11);
        tbl[13] = mk(1,1,32'h11,      0,0, 1,2,32'h22,       1,1,32'h11,       32'h10,  1,2'b11);
        tbl[14] = mk(0,0,0,           0,0, 0,0,0,            1,2,32'h22,       32'h10,  0,2'b11);
        tbl[15] = mk(0,0,0,           0,0, 0,0,0,            0,2,32'h22,       32'h10,  0,2'b11);

        // Reset state while clrn is held low
        #12;
        chk("reset_state", {bus.rf_we, bus.rf_wn, bus.rf_d, bus.pend, bus.occ, bus.err, bus.lng_ready},
                           {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 2'b00, 1'b1});
        @(negedge clk);
        clrn = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].alu_we, tbl[i].alu_wn, tbl[i].alu_d, tbl[i].iss_v, tbl[i].iss_wn,
                  tbl[i].lng_v, tbl[i].lng_wn, tbl[i].lng_d);
            tick();
            chk($sformatf("vec%0d {we,wn,d,pend,occ,err,rdy}", i),
                {bus.rf_we, bus.rf_wn, bus.rf_d, bus.pend, bus.occ, bus.err, bus.lng_ready},
                {tbl[i].e_we, tbl[i].e_wn, tbl[i].e_d, tbl[i].e_pend, tbl[i].e_occ, tbl[i].e_err,
                 (tbl[i].e_occ != 3'd4)});
        end

        // Reset mid-stream with two queued entries and a write in flight
        drive(1, 1, 32'hAA, 1, 6, 1, 20, 32'h20);
        tick();
        drive(1, 1, 32'hAB, 0, 0, 1, 21, 32'h21);
        tick();
        chk("pre_reset {we,occ}", {bus.rf_we, bus.occ}, {1'b1, 3'd2});
        idle();
        #2;
        clrn = 1'b0;
        #1;
        chk("async_reset {we,occ,pend,err,rdy}", {bus.rf_we, bus.occ, bus.pend, bus.err, bus.lng_ready},
                                                 {1'b0, 3'd0, 32'd0, 2'b00, 1'b1});
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_reset%0d {we,occ}", c), {bus.rf_we, bus.occ}, {1'b0, 3'd0});
        end

        // FIFO fill while the ALU hogs the port, then ordered drain
        do_reset();
        begin
            int k;
            k = 0;
            for (int c = 0; c < 14; c++) begin
                drive((c < 8), 5'd1, 32'hA000 + c, 0, 0,
                      (k < 5), 5'(8 + k), 32'h100 + 8 + k);
                #1;
                chk($sformatf("fill%0d lng_ready", c), bus.lng_ready, exp_rdy[c][0]);
                if (exp_rdy[c] != 0 && k < 5) k++;
                @(posedge clk);
                #1;
                chk($sformatf("fill%0d {we,wn,d,occ}", c), {bus.rf_we, bus.rf_wn, bus.rf_d, bus.occ},
                    {exp_we[c][0], 5'(exp_wn[c]),
                     (c < 8) ? 32'hA000 + c : 32'h100 + exp_wn[c], 3'(exp_occ[c])});
            end
        end

        // FIFO-head write to r9 retires in the same cycle r9 is reissued
        do_reset();
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        tick();
        chk("iss9 pend", bus.pend, 32'h200);
        drive(1, 1, 32'h1, 0, 0, 1, 9, 32'h99);
        tick();
        chk("q9 {we,wn,occ}", {bus.rf_we, bus.rf_wn, bus.occ}, {1'b1, 5'd1, 3'd1});
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        tick();
        chk("pop9+iss9 {we,wn,d,pend,err,occ}", {bus.rf_we, bus.rf_wn, bus.rf_d, bus.pend, bus.err, bus.occ},
                                                {1'b1, 5'd9, 32'h99, 32'h200, 2'b00, 3'd0});
        idle();
        tick();
        chk("after9 {pend,err}", {bus.pend, bus.err}, {32'h200, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back controller on the writer side of the 32x32 register file's single write port. It merges ALU results, which have priority and no backpressure, with results from a long-latency unit (mul/div, loads), which use a valid/ready handshake. Long results that cannot be written immediately are buffered in a small FIFO. The block also keeps a per-register pending scoreboard for long operations, and registers the regfile write controls (we, wn, d).

Parameters:
DEPTH, 4, long-result FIFO entries; power of 2, >= 2
AW, log2(DEPTH), FIFO pointer width (derived)

Ports:
clk  input  1  clock, all state updates on posedge
clrn  input  1  reset, asynchronous, active-low
alu_we  input  1  ALU result valid this cycle
alu_wn  input  5  ALU destination register
alu_d  input  32  ALU result
iss_valid  input  1  long operation issued this cycle
iss_wn  input  5  destination of issued long operation
lng_valid  input  1  long result valid
lng_wn  input  5  long result destination
lng_d  input  32  long result data
lng_ready  output  1  FIFO can accept a long result
rf_we  output  1  regfile write enable (registered)
rf_wn  output  5  regfile write register (registered)
rf_d  output  32  regfile write data (registered)
pend  output  32  pending-long-write scoreboard, bit r = register r
occ  output  AW+1  FIFO occupancy
err  output  2  sticky errors: [0] ALU WAW on pending reg, [1] issue to already-pending reg

Behaviour:
- Reset (clrn low, async): rf_we=0, rf_wn=0, rf_d=0, FIFO empty, occ=0, pend=0, err=0. lng_ready=1 during and after reset.
- lng_ready = (occ != DEPTH). It is derived from registered occ only, never from same-cycle inputs.
- Long accept: lng_valid && lng_ready. An accepted result with lng_wn==0 is discarded: no push, no write, no pend change.
- ALU valid: alu_we && alu_wn!=0. ALU writes to r0 are ignored.
- Write select each cycle, in priority order:
  1. ALU valid -> ALU.
  2. Else FIFO non-empty -> pop head.
  3. Else accepted long result with lng_wn!=0 -> direct write, not pushed.
  4. Else none.
- Push rule: an accepted long result (wn!=0) is pushed unless it was taken directly by rule 3.
- Push and pop in the same cycle: occ unchanged, FIFO order preserved.
- Latency: selected write appears on rf_we/rf_wn/rf_d in the cycle after selection. rf_we=0 in any cycle following one with no selection. rf_wn and rf_d hold their last values when rf_we=0.
- Ordering: long results are written strictly in acceptance order; the FIFO never reorders. The ALU may bypass queued long results.
- FIFO: circular buffer, wr/rd pointers AW bits wrapping DEPTH-1 -> 0, occ counts 0..DEPTH.
- Scoreboard, per register r (r0 never set):
  - Set: iss_valid && iss_wn==r && r!=0.
  - Clear: a long write to r is selected (rule 2 or 3).
  - Set and clear of the same r in the same cycle -> set wins (new op outstanding).
  - pend updates at the same edge as rf_* capture.
- Errors, set one cycle after the cause, sticky until reset:
  - err[0]: ALU valid with pend[alu_wn]=1.
  - err[1]: iss_valid, iss_wn!=0, pend[iss_wn]=1 and not cleared in the same cycle.
- Reset mid-operation: FIFO contents dropped, pend cleared, any in-flight output write cancelled (rf_we=0).
- No combinational path from inputs to outputs.

Test Plan:
1. Reset with clrn=0 mid-stream (FIFO holding 2 entries) -> immediately rf_we=0, occ=0, pend=0, err=0, lng_ready=1; after release, no stale writes appear.
2. ALU write alu_wn=5, alu_d=0x00001234 in cycle N -> cycle N+1 shows rf_we=1, rf_wn=5, rf_d=0x00001234. alu_we=1 with alu_wn=0 -> rf_we=0 next cycle.
3. iss wn=7 -> pend[7]=1 next cycle. Later lng_valid wn=7, d=0xDEADBEEF, with no ALU and an empty FIFO -> next cycle rf_we=1, rf_wn=7, rf_d=0xDEADBEEF; pend[7]=0 and occ=0.
4. ALU valid for 8 consecutive cycles while lng_valid presents regs 8..12 back-to-back (DEPTH=4):
   - Results for 8..11 are accepted; occ reaches 4 and lng_ready drops; the result for reg 12 is held.
   - After the ALU stops, rf_wn sequence is 8, 9, 10, 11, 12, one per cycle.
   - Reg 12 is accepted when occ falls to 3, then pushed and popped in order.
5. Same cycle: FIFO-head write to reg 9 selected and iss_wn=9 -> pend[9] stays 1 and err[1] stays 0.
6. With pend[3]=1, ALU write alu_wn=3 -> err[0]=1 the next cycle and remains 1 afterwards. With pend[4]=1, iss_wn=4 -> err[1]=1.
